// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (5-8 data bits, optional parity, 1-2 stop bits)
// feeding a small ready/valid FIFO with sticky overrun reporting.
module uart_rx_fifo #(
    parameter int unsigned DIV        = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         resetb,
    input  logic                         ser_rx,
    output logic [DATA_BITS-1:0]         rd_data,
    output logic                         rd_frame_err,
    output logic                         rd_parity_err,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic                         overrun,
    input  logic                         overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned BIT_W = 4;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ENT_W = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_e;

    logic [1:0]           sync_q;
    logic                 rx_s;
    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic                 push_q;
    logic [ENT_W-1:0]     push_ent_q;
    logic                 cnt_last_c;
    logic                 stop_fe_c;
    logic                 par_x_c;

    // Two-flop synchronizer; idle-high reset value avoids a false start.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], ser_rx};
    end
    assign rx_s = sync_q[1];

    assign cnt_last_c = (cnt_q == CNT_W'(DIV - 1));
    assign stop_fe_c  = frm_err_q | ~rx_s;
    assign par_x_c    = (^shift_q) ^ rx_s;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            push_q     <= 1'b0;
            push_ent_q <= '0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt_q   <= '0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        cnt_q     <= '0;
                        bit_q     <= '0;
                        par_err_q <= 1'b0;
                        frm_err_q <= 1'b0;
                        state_q   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_last_c) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                            bit_q   <= '0;
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt_last_c) begin
                        cnt_q     <= '0;
                        par_err_q <= (PARITY == 1) ? ~par_x_c : par_x_c;
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_last_c) begin
                        cnt_q     <= '0;
                        frm_err_q <= stop_fe_c;
                        if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                            bit_q      <= '0;
                            push_q     <= 1'b1;
                            push_ent_q <= {par_err_q, stop_fe_c, shift_q};
                            // A low line at a failed stop is a break: wait it out.
                            state_q    <= (stop_fe_c && !rx_s) ? S_WAIT_HIGH : S_IDLE;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic [LVL_W-1:0] level_c;
    logic             pop_c;
    logic             push_ok_c;

    assign level_c   = wr_ptr_q - rd_ptr_q;
    assign rd_valid  = (level_c != '0);
    assign pop_c     = rd_valid && rd_ready;
    assign push_ok_c = push_q && ((level_c != LVL_W'(FIFO_DEPTH)) || pop_c);

    // FIFO storage and pointers; a full FIFO still accepts a push when popped in the same cycle.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            overrun  <= 1'b0;
        end else begin
            if (push_ok_c) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= push_ent_q;
                wr_ptr_q <= wr_ptr_q + LVL_W'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + LVL_W'(1);
            if (push_q && !push_ok_c) overrun <= 1'b1;
            else if (overrun_clr)     overrun <= 1'b0;
        end
    end

    assign {rd_parity_err, rd_frame_err, rd_data} = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign fifo_level = level_c;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: an 8N1 instance and a 7E1 instance checked
// against a frame-level model (expected entry per transmitted frame, queue of entries).
module tb_uart_rx_fifo;
    localparam int unsigned DIV_A = 16;
    localparam int unsigned DIV_B = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT_A = 3 + DIV_A / 2 + (8 + 0 + 1) * DIV_A;
    localparam int unsigned LAT_B = 3 + DIV_B / 2 + (7 + 1 + 1) * DIV_B;

    logic       clk = 1'b0;
    logic       resetb;
    logic       ser_a, ser_b, ready_a, ready_b, clr_a, clr_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       fe_a, pe_a, valid_a, ovr_a;
    logic       fe_b, pe_b, valid_b, ovr_b;
    logic [2:0] lvl_a, lvl_b;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.DIV(DIV_A), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .resetb(resetb), .ser_rx(ser_a),
        .rd_data(data_a), .rd_frame_err(fe_a), .rd_parity_err(pe_a), .rd_valid(valid_a),
        .rd_ready(ready_a), .overrun(ovr_a), .overrun_clr(clr_a), .fifo_level(lvl_a)
    );

    uart_rx_fifo #(.DIV(DIV_B), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_b (
        .clk(clk), .resetb(resetb), .ser_rx(ser_b),
        .rd_data(data_b), .rd_frame_err(fe_b), .rd_parity_err(pe_b), .rd_valid(valid_b),
        .rd_ready(ready_b), .overrun(ovr_b), .overrun_clr(clr_b), .fifo_level(lvl_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int div_of(input int w);
        return (w == 0) ? int'(DIV_A) : int'(DIV_B);
    endfunction

    function automatic logic [9:0] obs(input int w);
        if (w == 0) return {pe_a, fe_a, data_a};
        return {pe_b, fe_b, 1'b0, data_b};
    endfunction

    function automatic int lvl(input int w);
        return (w == 0) ? int'(lvl_a) : int'(lvl_b);
    endfunction

    function automatic logic valid(input int w);
        return (w == 0) ? valid_a : valid_b;
    endfunction

    function automatic logic ovr(input int w);
        return (w == 0) ? ovr_a : ovr_b;
    endfunction

    // Expected FIFO entry {pe, fe, data}: parity error iff the sent parity bit was wrong,
    // frame error iff the sent stop bit was low.
    function automatic logic [9:0] model(input int w, input logic [7:0] d, input bit pflip, input bit slow);
        if (w == 0) return {1'b0, slow, d};
        return {pflip, slow, 1'b0, d[6:0]};
    endfunction

    task automatic drive(input int w, input logic b);
        if (w == 0) ser_a = b; else ser_b = b;
    endtask

    task automatic set_ready(input int w, input logic b);
        if (w == 0) ready_a = b; else ready_b = b;
    endtask

    task automatic pulse_clr(input int w);
        if (w == 0) clr_a = 1'b1; else clr_b = 1'b1;
        cycles(1);
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    // Transmit one frame; called at a falling clock edge, returns at one with the line idle.
    task automatic send(input int w, input logic [7:0] d, input bit pflip, input bit slow);
        logic [11:0] v;
        int          n;
        int          nb;
        nb = (w == 0) ? 8 : 7;
        v  = '0;
        for (int i = 0; i < nb; i++) v[1+i] = d[i];
        n = 1 + nb;
        if (w == 1) begin
            v[n] = (^d[6:0]) ^ pflip;
            n++;
        end
        v[n] = ~slow;
        n++;
        for (int i = 0; i < n; i++) begin
            drive(w, v[i]);
            cycles(div_of(w));
        end
        drive(w, 1'b1);
    endtask

    task automatic pop_check(input int w, input logic [9:0] e, input string tag);
        chk({tag, "_valid"}, 32'(valid(w)), 32'd1);
        chk({tag, "_entry"}, 32'(obs(w)), 32'(e));
        set_ready(w, 1'b1);
        cycles(1);
        set_ready(w, 1'b0);
    endtask

    task automatic reset_vals(input int w, input string tag);
        chk({tag, "_valid"}, 32'(valid(w)), 32'd0);
        chk({tag, "_level"}, 32'(lvl(w)), 32'd0);
        chk({tag, "_overrun"}, 32'(ovr(w)), 32'd0);
        chk({tag, "_entry"}, 32'(obs(w)), 32'd0);
    endtask

    // Cycles from the first edge seeing the start bit to the edge after which rd_valid is high.
    task automatic measure(input int w, input logic [7:0] d, input int exp_lat, input string tag);
        int c;
        c = 0;
        fork
            send(w, d, 1'b0, 1'b0);
            begin
                @(posedge clk);
                do begin
                    @(posedge clk);
                    c++;
                    #1;
                end while (!valid(w) && c < 400);
            end
        join
        chk(tag, 32'(c), 32'(exp_lat));
    endtask

    task automatic drain(input int w);
        int guard;
        bit r;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            chk("drain_valid", 32'(valid(w)), 32'd1);
            chk("drain_entry", 32'(obs(w)), 32'(exp_q[0]));
            r = 1'($urandom_range(0, 1));
            set_ready(w, r);
            cycles(1);
            if (r) void'(exp_q.pop_front());
            guard++;
        end
        set_ready(w, 1'b0);
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rand_round(input int w);
        int         k;
        int         div;
        logic [7:0] d;
        bit         pf, sl;
        div = div_of(w);
        k   = int'($urandom_range(1, 6));
        exp_q.delete();
        for (int i = 0; i < k; i++) begin
            d  = 8'($urandom);
            pf = (w == 1) && ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 4) == 0);
            if (exp_q.size() < int'(DEPTH)) exp_q.push_back(model(w, d, pf, sl));
            send(w, d, pf, sl);
            if (sl) cycles(div + int'($urandom_range(0, div)));
            else    cycles(int'($urandom_range(0, div)));
        end
        cycles(div);
        chk("rnd_level", 32'(lvl(w)), 32'((k > int'(DEPTH)) ? int'(DEPTH) : k));
        chk("rnd_overrun", 32'(ovr(w)), 32'((k > int'(DEPTH)) ? 1 : 0));
        drain(w);
        chk("rnd_empty", 32'(valid(w)), 32'd0);
        pulse_clr(w);
        chk("rnd_ovr_clr", 32'(ovr(w)), 32'd0);
    endtask

    // Fill the FIFO, then raise rd_ready only for the edge on which the fifth push lands.
    task automatic full_push_pop();
        for (int i = 0; i < 4; i++) send(0, 8'(8'h10 + i), 1'b0, 1'b0);
        cycles(DIV_A);
        chk("full_level", 32'(lvl_a), 32'd4);
        fork
            send(0, 8'h14, 1'b0, 1'b0);
            begin
                @(posedge clk);
                repeat (LAT_A - 1) @(posedge clk);
                @(negedge clk);
                chk("full_head", 32'(obs(0)), 32'h010);
                ready_a = 1'b1;
                @(negedge clk);
                ready_a = 1'b0;
            end
        join
        cycles(DIV_A);
        chk("pushpop_level", 32'(lvl_a), 32'd4);
        chk("pushpop_overrun", 32'(ovr_a), 32'd0);
        for (int i = 1; i < 5; i++) pop_check(0, 10'(8'h10 + i), "pushpop_pop");
    endtask

    initial begin
        resetb  = 1'b0;
        ser_a   = 1'b1;
        ser_b   = 1'b1;
        ready_a = 1'b0;
        ready_b = 1'b0;
        clr_a   = 1'b0;
        clr_b   = 1'b0;
        cycles(3);
        reset_vals(0, "rst_a");
        reset_vals(1, "rst_b");
        resetb = 1'b1;
        cycles(4);

        // Back-to-back 8N1 frames with start-to-valid latency.
        fork
            measure(0, 8'h55, int'(LAT_A), "lat_8n1");
            begin
                repeat (10 * DIV_A) @(negedge clk);
                send(0, 8'hA3, 1'b0, 1'b0);
            end
        join
        cycles(DIV_A);
        chk("b2b_level", 32'(lvl_a), 32'd2);
        pop_check(0, 10'h055, "b2b_first");
        pop_check(0, 10'h0A3, "b2b_second");

        // Short glitch is rejected, following frame is received.
        ser_a = 1'b0;
        cycles(3);
        ser_a = 1'b1;
        cycles(3 * DIV_A);
        chk("glitch_level", 32'(lvl_a), 32'd0);
        send(0, 8'h7E, 1'b0, 1'b0);
        cycles(DIV_A);
        pop_check(0, 10'h07E, "glitch_next");

        // Break: one zero frame with framing error, nothing more.
        ser_a = 1'b0;
        cycles(3 * 10 * DIV_A);
        ser_a = 1'b1;
        cycles(5 * DIV_A);
        chk("break_level", 32'(lvl_a), 32'd1);
        pop_check(0, 10'h100, "break_entry");
        send(0, 8'h3C, 1'b0, 1'b0);
        cycles(DIV_A);
        chk("after_break_level", 32'(lvl_a), 32'd1);
        pop_check(0, 10'h03C, "after_break");

        // Overrun on the fifth frame, then clear.
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 1'b0);
        cycles(DIV_A);
        chk("ovr_level", 32'(lvl_a), 32'd4);
        chk("ovr_set", 32'(ovr_a), 32'd1);
        for (int i = 1; i <= 4; i++) pop_check(0, 10'(i), "ovr_pop");
        chk("ovr_empty", 32'(valid_a), 32'd0);
        pulse_clr(0);
        chk("ovr_clr", 32'(ovr_a), 32'd0);

        full_push_pop();

        // Mid-frame asynchronous reset with a full, overrun FIFO.
        for (int i = 0; i < 5; i++) send(0, 8'(8'h20 + i), 1'b0, 1'b0);
        cycles(DIV_A);
        chk("pre_rst_ovr", 32'(ovr_a), 32'd1);
        fork
            send(0, 8'h00, 1'b0, 1'b0);
            begin
                cycles(50);
                resetb = 1'b0;
                #1;
                reset_vals(0, "async_rst");
            end
        join
        resetb = 1'b1;
        cycles(2 * DIV_A);
        chk("post_rst_level", 32'(lvl_a), 32'd0);
        send(0, 8'h5A, 1'b0, 1'b0);
        cycles(DIV_A);
        pop_check(0, 10'h05A, "post_rst_frame");

        for (int r = 0; r < 6; r++) rand_round(0);

        // 7E1: correct then inverted parity bit.
        measure(1, 8'h41, int'(LAT_B), "lat_7e1");
        send(1, 8'h41, 1'b1, 1'b0);
        cycles(DIV_B);
        chk("7e1_level", 32'(lvl_b), 32'd2);
        pop_check(1, 10'h041, "7e1_good");
        pop_check(1, 10'h241, "7e1_bad_par");

        for (int r = 0; r < 8; r++) rand_round(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
